can_tx_frame: RTL and testbench

Classic CAN 2.0A base-frame transmit sequencer. It serialises a latched request (ID, RTR, DLC, data) into the unstuffed bit stream feeding the bit stream processor's `tx_data_in` / `enable_stuffing` inputs, and computes CRC-15 internally. It advances only on `tx_point` pulses that are not stalled by stuff-bit insertion. It monitors the destuffed receive stream for arbitration loss and a missing acknowledge.

---
 rtl/can_tx_frame.sv | 110 +++++++++++
 tb/tb_can_tx_frame.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/can_tx_frame.sv
// can_tx_frame: CAN 2.0A base-frame transmit sequencer with CRC-15 and arbitration/ACK readback.
// Define CAN_TX_ARB_EN to enable the arbitration-loss compare; otherwise arb_lost stays 0.
module can_tx_frame #(
  parameter int IFS_BITS = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_point,
  input  logic        tx_stall,
  input  logic        sample_point,
  input  logic        rx_stall,
  input  logic        rx_bit,
  input  logic        req,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        busy,
  output logic        tx_data,
  output logic        stuff_en,
  output logic        done,
  output logic        arb_lost,
  output logic        ack_err
);
  localparam logic [3:0] S_IDLE = 4'd0, S_SOF = 4'd1, S_ARB = 4'd2, S_CTRL = 4'd3, S_DATA = 4'd4,
                         S_CRC = 4'd5, S_CRC_DEL = 4'd6, S_ACK_SLOT = 4'd7, S_ACK_DEL = 4'd8,
                         S_EOF = 4'd9, S_IFS = 4'd10;
  logic [3:0]  state, next_state, sent_field, dlc_r, nbytes;
  logic [6:0]  cnt, last;
  logic [10:0] id_r;
  logic        rtr_r, adv, rx_ok, arb_hit, ack_hit, abort;
  logic [63:0] data_r;
  logic [14:0] crc;
  assign nbytes = rtr_r ? 4'd0 : dlc_r > 4'd8 ? 4'd8 : dlc_r;
  assign adv = tx_point && !tx_stall;
  assign busy = state != S_IDLE;
  assign stuff_en = state >= S_SOF && state <= S_CRC;
  assign rx_ok = sample_point && !rx_stall && busy;
  assign ack_hit = rx_ok && sent_field == S_ACK_SLOT && rx_bit;
  assign abort = arb_hit || ack_hit;
  assign next_state = state == S_IFS ? S_IDLE : state == S_CTRL && nbytes == 4'd0 ? S_CRC : state + 4'd1;
  always_comb
    case (state)
      S_ARB:   last = 7'd11;
      S_CTRL:  last = 7'd5;
      S_DATA:  last = {nbytes, 3'b000} - 7'd1;
      S_CRC:   last = 7'd14;
      S_EOF:   last = 7'd6;
      S_IFS:   last = 7'(IFS_BITS - 1);
      default: last = 7'd0;
    endcase
  // CTRL carries IDE=0, r0=0 in its first two bits, then the raw DLC
  always_comb
    case (state)
      S_SOF:   tx_data = 1'b0;
      S_ARB:   tx_data = cnt < 7'd11 ? id_r[4'd10 - cnt[3:0]] : rtr_r;
      S_CTRL:  tx_data = cnt > 7'd1 && dlc_r[2'(3'd5 - cnt[2:0])];
      S_DATA:  tx_data = data_r[~cnt[5:0]];
      S_CRC:   tx_data = crc[4'd14 - cnt[3:0]];
      default: tx_data = 1'b1;
    endcase
`ifdef CAN_TX_ARB_EN
  logic sent_bit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sent_bit <= 1'b1;
    else if (adv) sent_bit <= tx_data;
  assign arb_hit = rx_ok && sent_field == S_ARB && sent_bit && !rx_bit;
`else
  assign arb_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      crc <= '0;
      sent_field <= S_IDLE;
      id_r <= '0;
      rtr_r <= 1'b0;
      dlc_r <= '0;
      data_r <= '0;
      done <= 1'b0;
      arb_lost <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      arb_lost <= arb_hit;
      ack_err <= ack_hit;
      if (!busy) begin
        crc <= '0;
        cnt <= '0;
        sent_field <= S_IDLE;
        if (req) begin
          state <= S_SOF;
          id_r <= id;
          rtr_r <= rtr;
          dlc_r <= dlc;
          data_r <= data;
        end
      end else if (abort) state <= S_IDLE;
      else if (adv) begin
        sent_field <= state;
        if (state <= S_DATA) crc <= {crc[13:0], 1'b0} ^ (crc[14] ^ tx_data ? 15'h4599 : 15'h0000);
        if (cnt == last) begin
          state <= next_state;
          cnt <= '0;
          done <= state == S_IFS;
        end else cnt <= cnt + 7'd1;
      end
    end
endmodule

// File: tb/tb_can_tx_frame.sv
// tb_can_tx_frame: table-driven and randomized frames against a bit-level CAN frame model with a stuffing BSP model.
module tb_can_tx_frame;
  localparam int IFS = 3;
`ifdef CAN_TX_ARB_EN
  localparam bit ARB_ON = 1'b1;
`else
  localparam bit ARB_ON = 1'b0;
`endif
  typedef struct {
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    bit          stall;
    int          force_idx;
    logic        ack_val;
    bit          exp_arb;
  } vec_t;

  logic clk = 0, rst_n = 0, tx_point = 0, tx_stall = 0, sample_point = 0, rx_stall = 0, rx_bit = 1, req = 0;
  logic [10:0] id = '0;
  logic rtr = 0;
  logic [3:0] dlc = '0;
  logic [63:0] data = '0;
  logic busy, tx_data, stuff_en, done, arb_lost, ack_err;

  can_tx_frame #(.IFS_BITS(IFS)) dut (
    .clk(clk), .rst_n(rst_n), .tx_point(tx_point), .tx_stall(tx_stall), .sample_point(sample_point),
    .rx_stall(rx_stall), .rx_bit(rx_bit), .req(req), .id(id), .rtr(rtr), .dlc(dlc), .data(data),
    .busy(busy), .tx_data(tx_data), .stuff_en(stuff_en), .done(done), .arb_lost(arb_lost), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int n_done, n_arb, n_ack, bad_post, hold_bad, fall_idx;
  bit cons[$];
  bit exp_q[$];
  vec_t vecs[6];

  always @(negedge clk) if (rst_n) begin
    if (done) n_done++;
    if (arb_lost) n_arb++;
    if (ack_err) n_ack++;
    if ((done || arb_lost || ack_err) && (busy || !tx_data || stuff_en)) bad_post++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input vec_t v);
    return v.rtr ? 0 : (v.dlc > 8 ? 8 : int'(v.dlc));
  endfunction

  // Unstuffed frame as the bus should carry it, CRC by the textbook shift-register definition
  function automatic void build_ref(input vec_t v);
    logic [14:0] c = '0;
    logic fb;
    int n = nbytes(v);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 10; i >= 0; i--) exp_q.push_back(v.id[i]);
    exp_q.push_back(v.rtr);
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) exp_q.push_back(v.dlc[i]);
    for (int i = 0; i < 8 * n; i++) exp_q.push_back(v.data[63 - i]);
    for (int i = 0; i < exp_q.size(); i++) begin
      fb = c[14] ^ exp_q[i];
      c = {c[13:0], 1'b0};
      if (fb) c = c ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) exp_q.push_back(c[i]);
    repeat (10 + IFS) exp_q.push_back(1'b1);
  endfunction

  task automatic send(input vec_t v, input int stop_after);
    int guard = 0, run = 0, idx;
    int ack_idx = 35 + 8 * nbytes(v);
    bit st, bus, last_bus = 1, se_seen = 0;
    logic cur;
    cons.delete();
    hold_bad = 0; fall_idx = -1; n_done = 0; n_arb = 0; n_ack = 0; bad_post = 0;
    id = v.id; rtr = v.rtr; dlc = v.dlc; data = v.data; req = 1;
    @(negedge clk);
    req = 0;
    check("accept_sof", {busy, tx_data, stuff_en}, 3'b101);
    while (busy && guard < 300) begin
      if (cons.size() == stop_after) return;
      guard++;
      if (stuff_en) se_seen = 1;
      else if (se_seen && fall_idx < 0) fall_idx = cons.size();
      cur = tx_data;
      st = v.stall && stuff_en && run == 5;
      bus = st ? ~last_bus : cur;
      if (stuff_en) run = bus == last_bus ? run + 1 : 1;
      last_bus = bus;
      if (cons.size() < 4) begin
        req = 1'($urandom_range(0, 1));
        id = 11'($urandom);
        dlc = 4'($urandom);
        data = {$urandom, $urandom};
      end else req = 0;
      tx_point = 1; tx_stall = st;
      @(negedge clk);
      tx_point = 0; tx_stall = 0;
      if (st) begin
        if (tx_data !== cur) hold_bad++;
      end else cons.push_back(cur);
      idx = cons.size() - 1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sample_point = 1; rx_stall = st; rx_bit = bus;
      if (!st && idx == v.force_idx) rx_bit = 0;
      if (!st && idx == ack_idx) rx_bit = v.ack_val;
      @(negedge clk);
      sample_point = 0; rx_stall = 0; rx_bit = 1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
    end
    check("frame_ends", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    int n = nbytes(v), bad = -1, exp_len;
    bit arb = v.exp_arb && ARB_ON, ack = v.ack_val && !arb;
    build_ref(v);
    send(v, -1);
    exp_len = arb ? v.force_idx + 1 : ack ? 36 + 8 * n : 47 + 8 * n;
    check("bit_count", cons.size(), exp_len);
    for (int i = 0; i < cons.size() && i < exp_len; i++)
      if (cons[i] != exp_q[i]) begin bad = i; break; end
    check("first_bad_bit", bad, -1);
    check("done_pulses", n_done, (arb || ack) ? 0 : 1);
    check("arb_pulses", n_arb, arb);
    check("ack_pulses", n_ack, ack);
    check("idle_with_pulse", bad_post, 0);
    check("idle_after", {busy, tx_data, stuff_en}, 3'b010);
    if (v.stall) check("stall_hold", hold_bad, 0);
    if (!arb && !ack) check("stuff_fall_idx", fall_idx, 34 + 8 * n);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{id:11'h123, rtr:1'b0, dlc:4'd1, data:64'hA500_0000_0000_0000, stall:1'b0, force_idx:-1, ack_val:1'b0, exp_arb:1'b0};
    vecs[1] = '{id:11'h000, rtr:1'b0, dlc:4'd0, data:64'h0, stall:1'b1, force_idx:-1, ack_val:1'b0, exp_arb:1'b0};
    vecs[2] = '{id:11'h7FF, rtr:1'b0, dlc:4'd2, data:64'hDEAD_0000_0000_0000, stall:1'b0, force_idx:4, ack_val:1'b0, exp_arb:1'b1};
    vecs[3] = '{id:11'h2AA, rtr:1'b0, dlc:4'd3, data:64'h0F1E_2D00_0000_0000, stall:1'b1, force_idx:-1, ack_val:1'b1, exp_arb:1'b0};
    vecs[4] = '{id:11'h1C4, rtr:1'b1, dlc:4'd8, data:64'hFFFF_FFFF_FFFF_FFFF, stall:1'b1, force_idx:-1, ack_val:1'b0, exp_arb:1'b0};
    vecs[5] = '{id:11'h456, rtr:1'b0, dlc:4'd12, data:64'h0000_00FF_FFFF_0011, stall:1'b1, force_idx:-1, ack_val:1'b0, exp_arb:1'b0};
    repeat (3) @(negedge clk);
    check("reset_idle", {busy, tx_data, stuff_en, done, arb_lost, ack_err}, 6'b010000);
    rst_n = 1;
    @(negedge clk);
    foreach (vecs[i]) run_vec(vecs[i]);
    for (int k = 0; k < 8; k++) begin
      v = '{id:11'($urandom), rtr:($urandom_range(0, 3) == 0), dlc:4'($urandom), data:{$urandom, $urandom},
            stall:1'($urandom_range(0, 1)), force_idx:-1, ack_val:($urandom_range(0, 3) == 0), exp_arb:1'b0};
      run_vec(v);
    end
    v = '{id:11'h321, rtr:1'b0, dlc:4'd4, data:{$urandom, $urandom}, stall:1'b1, force_idx:-1, ack_val:1'b0, exp_arb:1'b0};
    send(v, 24);
    #2 rst_n = 0;
    #1 check("async_reset_idle", {busy, tx_data, stuff_en, done, arb_lost, ack_err}, 6'b010000);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    v.id = 11'h055;
    v.dlc = 4'd2;
    run_vec(v);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
